// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU/bonus control codes and forwarding selects.
package id_ex_operand_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int SHAMT_W    = 5;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1011;
    localparam logic [3:0] ALU_SHIFT = 4'b1111;

    localparam logic [2:0] BONUS_NONE = 3'b000;
    localparam logic [2:0] BONUS_SRL  = 3'b101;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// Forwarding resolution for one source operand of the instruction sitting in EX.
module fwd_unit
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] reg_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output fwd_sel_e          sel_o,
    output logic [DATA_W-1:0] data_o
);

    // Register 0 is hardwired, so it never takes a bypass; the younger EX/MEM result wins.
    always_comb begin
        sel_o  = FWD_RF;
        data_o = rf_data_i;
        if (reg_i != '0) begin
            if (exmem_reg_write_i && (exmem_rd_i == reg_i)) begin
                sel_o  = FWD_EXMEM;
                data_o = exmem_result_i;
            end else if (memwb_reg_write_i && (memwb_rd_i == reg_i)) begin
                sel_o  = FWD_MEMWB;
                data_o = memwb_data_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection and ALU operand formation.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [3:0]        id_alu_ctrl_i,
    input  logic [2:0]        id_bonus_ctrl_i,
    input  logic              id_alu_src_imm_i,
    input  logic              id_shift_imm_i,
    input  logic              id_uses_rt_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    output logic [2:0]        bonus_ctrl_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o
);

    import id_ex_operand_stage_pkg::*;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [2:0]        bonus_ctrl_q, bonus_ctrl_d;
    logic              alu_src_imm_q, alu_src_imm_d;
    logic              shift_imm_q, shift_imm_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    logic              loadUseHazard;
    logic [DATA_W-1:0] rsFwdData, rtFwdData;
    fwd_sel_e          rsSel, rtSel;
    logic [3:0]        fwdSelUnused;
    logic [DATA_W-1:0] shamtExt;

    // A load in EX cannot feed a dependent instruction in ID; a frozen pipe never stalls.
    assign loadUseHazard = !hold_i && valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
                           ((rd_q == id_rs_i) || (id_uses_rt_i && (rd_q == id_rt_i)));
    assign stall_o = loadUseHazard;

    // Flush and stall both insert a fully cleared bubble; hold keeps the slot untouched.
    always_comb begin
        valid_d       = valid_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        imm_d         = imm_q;
        shamt_d       = shamt_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        alu_ctrl_d    = alu_ctrl_q;
        bonus_ctrl_d  = bonus_ctrl_q;
        alu_src_imm_d = alu_src_imm_q;
        shift_imm_d   = shift_imm_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        if (flush_i || loadUseHazard) begin
            valid_d       = 1'b0;
            rs_data_d     = '0;
            rt_data_d     = '0;
            imm_d         = '0;
            shamt_d       = '0;
            rs_d          = '0;
            rt_d          = '0;
            rd_d          = '0;
            alu_ctrl_d    = '0;
            bonus_ctrl_d  = '0;
            alu_src_imm_d = 1'b0;
            shift_imm_d   = 1'b0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            mem_to_reg_d  = 1'b0;
        end else if (!hold_i) begin
            valid_d       = id_valid_i;
            rs_data_d     = id_rs_data_i;
            rt_data_d     = id_rt_data_i;
            imm_d         = id_imm_i;
            shamt_d       = id_shamt_i;
            rs_d          = id_rs_i;
            rt_d          = id_rt_i;
            rd_d          = id_rd_i;
            alu_ctrl_d    = id_alu_ctrl_i;
            bonus_ctrl_d  = id_bonus_ctrl_i;
            alu_src_imm_d = id_alu_src_imm_i;
            shift_imm_d   = id_shift_imm_i;
            reg_write_d   = id_reg_write_i && id_valid_i;
            mem_read_d    = id_mem_read_i && id_valid_i;
            mem_write_d   = id_mem_write_i && id_valid_i;
            mem_to_reg_d  = id_mem_to_reg_i && id_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= 1'b0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            alu_ctrl_q    <= '0;
            bonus_ctrl_q  <= '0;
            alu_src_imm_q <= 1'b0;
            shift_imm_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_q         <= imm_d;
            shamt_q       <= shamt_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            alu_ctrl_q    <= alu_ctrl_d;
            bonus_ctrl_q  <= bonus_ctrl_d;
            alu_src_imm_q <= alu_src_imm_d;
            shift_imm_q   <= shift_imm_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
        end
    end

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .reg_i             (rs_q),
        .rf_data_i         (rs_data_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_data_i      (memwb_data_i),
        .sel_o             (rsSel),
        .data_o            (rsFwdData)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .reg_i             (rt_q),
        .rf_data_i         (rt_data_q),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .exmem_result_i    (exmem_result_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .memwb_data_i      (memwb_data_i),
        .sel_o             (rtSel),
        .data_o            (rtFwdData)
    );

    // Selects only matter for waveform debug; the datapath consumes the resolved data.
    assign fwdSelUnused = {rsSel, rtSel};

    assign shamtExt = {{(DATA_W-SHAMT_W){1'b0}}, shamt_q};

    assign alu_src1_o      = valid_q ? (shift_imm_q ? shamtExt : rsFwdData) : '0;
    assign alu_src2_o      = valid_q ? (alu_src_imm_q ? imm_q : rtFwdData) : '0;
    assign alu_ctrl_o      = alu_ctrl_q;
    assign bonus_ctrl_o    = bonus_ctrl_q;
    assign ex_rd_o         = rd_q;
    assign ex_store_data_o = rtFwdData;
    assign ex_valid_o      = valid_q;
    assign ex_reg_write_o  = reg_write_q;
    assign ex_mem_read_o   = mem_read_q;
    assign ex_mem_write_o  = mem_write_q;
    assign ex_mem_to_reg_o = mem_to_reg_q;

endmodule
